// File: rtl/demux_ch_deser.sv
// Two-channel bit-serial deserializer: steers each accepted bit into its channel's
// shift register and presents finished W-bit words on per-channel valid/ready ports.
module demux_ch_deser #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         sel,
  input  logic         din,
  output logic         in_ready,
  output logic [W-1:0] out0_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [W-1:0] out1_data,
  output logic         out1_valid,
  input  logic         out1_ready
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned NCH = 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [W-1:0]  sh_q       [NCH];
  logic [W-1:0]  sh_d       [NCH];
  logic [CW-1:0] cnt_q      [NCH];
  logic [CW-1:0] cnt_d      [NCH];
  logic          full_q     [NCH];
  logic          full_d     [NCH];
  logic [W-1:0]  out_data_q [NCH];
  logic [W-1:0]  out_data_d [NCH];
  logic          out_valid_q[NCH];
  logic          out_valid_d[NCH];

  logic          out_ready_c[NCH];
  logic          accept_c   [NCH];
  logic          can_load_c [NCH];
  logic [W-1:0]  shifted_c  [NCH];

  assign out_ready_c[0] = out0_ready;
  assign out_ready_c[1] = out1_ready;

  // A channel only stalls its own input once a second word is parked in sh.
  assign in_ready = !full_q[sel];

  assign out0_data  = out_data_q[0];
  assign out0_valid = out_valid_q[0];
  assign out1_data  = out_data_q[1];
  assign out1_valid = out_valid_q[1];

  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      sh_d[c]        = sh_q[c];
      cnt_d[c]       = cnt_q[c];
      full_d[c]      = full_q[c];
      out_data_d[c]  = out_data_q[c];
      out_valid_d[c] = out_valid_q[c];

      accept_c[c]   = in_valid && !full_q[c] && (sel == 1'(c));
      can_load_c[c] = !out_valid_q[c] || out_ready_c[c];
      shifted_c[c]  = {sh_q[c][W-2:0], din};

      if (out_valid_q[c] && out_ready_c[c]) begin
        out_valid_d[c] = 1'b0;
      end

      // While full the input is stalled, so only the parked word can move.
      if (full_q[c]) begin
        if (can_load_c[c]) begin
          out_data_d[c]  = sh_q[c];
          out_valid_d[c] = 1'b1;
          full_d[c]      = 1'b0;
        end
      end else if (accept_c[c]) begin
        sh_d[c] = shifted_c[c];
        if (cnt_q[c] == CNT_LAST) begin
          cnt_d[c] = '0;
          if (can_load_c[c]) begin
            out_data_d[c]  = shifted_c[c];
            out_valid_d[c] = 1'b1;
          end else begin
            full_d[c] = 1'b1;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(NCH); c++) begin
        sh_q[c]        <= '0;
        cnt_q[c]       <= '0;
        full_q[c]      <= 1'b0;
        out_data_q[c]  <= '0;
        out_valid_q[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < int'(NCH); c++) begin
        sh_q[c]        <= sh_d[c];
        cnt_q[c]       <= cnt_d[c];
        full_q[c]      <= full_d[c];
        out_data_q[c]  <= out_data_d[c];
        out_valid_q[c] <= out_valid_d[c];
      end
    end
  end

endmodule
